decode_replay_stage: RTL and testbench

//  Parametrised decode stage for the 5-stage pipe. Sits between instruction memory (fixed
//  MEM_LAT read latency) and execute/regfile-read. Replaces cycle-count stall tracking with
//  an ordered replay FIFO for in-flight fetch words. Adds an optional load-use interlock that

---
 rtl/decode_replay_stage.sv | 195 +++++++++++++++++++
 tb/tb_decode_replay_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_replay_stage.sv
// Decode stage with an ordered replay FIFO for fetch words that arrive while the stage
// is held, plus an optional load-use interlock that inserts its own bubble.
module decode_replay_stage #(
    parameter int XLEN       = 32,
    parameter int RIDX       = 5,
    parameter int RBUF_DEPTH = 2,
    parameter int LOAD_USE   = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              halt,
    input  logic                              flush,
    input  logic                              stall,
    input  logic [31:0]                       instr_in,
    input  logic                              instr_valid,
    input  logic [XLEN-1:0]                   pc_in,
    output logic                              valid_out,
    output logic [XLEN-1:0]                   pc_out,
    output logic [4:0]                        opcode_out,
    output logic [RIDX-1:0]                   s1_out,
    output logic [RIDX-1:0]                   s2_out,
    output logic [RIDX-1:0]                   tgt1_out,
    output logic [RIDX-1:0]                   tgt2_out,
    output logic [4:0]                        alu_op_out,
    output logic [XLEN-1:0]                   imm_out,
    output logic [4:0]                        branch_code_out,
    output logic                              is_load_out,
    output logic                              is_store_out,
    output logic                              is_branch_out,
    output logic                              is_post_inc_out,
    output logic                              halt_out,
    output logic                              hazard_stall,
    output logic [$clog2(RBUF_DEPTH+1)-1:0]   rbuf_count,
    output logic                              rbuf_ovf
);
    localparam int CW = $clog2(RBUF_DEPTH + 1);
    localparam int PW = (RBUF_DEPTH > 1) ? $clog2(RBUF_DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(RBUF_DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(RBUF_DEPTH);

    logic [31:0]     ibuf_mem [RBUF_DEPTH];
    logic [XLEN-1:0] pbuf_mem [RBUF_DEPTH];
    logic [PW-1:0]   head_reg, tail_reg;
    logic [CW-1:0]   count_reg;
    logic            ovf_reg;

    logic            fifo_empty, fifo_full, hold, push_req, push_ok, pop, out_valid;
    logic [31:0]     c_instr;
    logic [XLEN-1:0] c_pc;
    logic            c_valid;

    logic [4:0]      opc, alu_op, ra, rb;
    logic            d_mem, d_load, d_store, d_branch, d_post, d_halt, ld_alt, inc_mode;
    logic [RIDX-1:0] d_s1, d_s2, d_tgt1, d_tgt2;
    logic [XLEN-1:0] d_imm, sx12;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == FULL_CNT);
    assign c_instr    = fifo_empty ? instr_in : ibuf_mem[head_reg];
    assign c_pc       = fifo_empty ? pc_in : pbuf_mem[head_reg];
    assign c_valid    = fifo_empty ? instr_valid : 1'b1;

    // Words enter the FIFO whenever they cannot bypass straight into decode,
    // so program order is preserved across holds.
    assign hold      = stall | hazard_stall;
    assign push_req  = instr_valid & (hold | ~fifo_empty);
    assign pop       = ~hold & ~fifo_empty;
    assign push_ok   = push_req & (~fifo_full | pop);
    assign out_valid = c_valid & ~flush & ~hazard_stall;

    assign rbuf_count = count_reg;
    assign rbuf_ovf   = ovf_reg;

    always_comb begin
        opc      = c_instr[31:27];
        alu_op   = (opc == 5'd0) ? c_instr[9:5] : c_instr[16:12];
        if (opc == 5'd13 || opc == 5'd14) begin
            ra = c_instr[9:5];
            rb = c_instr[4:0];
        end else begin
            ra = c_instr[26:22];
            rb = c_instr[21:17];
        end
        d_mem    = (opc >= 5'd3) && (opc <= 5'd11);
        ld_alt   = (opc == 5'd5) || (opc == 5'd8) || (opc == 5'd11);
        d_load   = d_mem & (ld_alt ? c_instr[22] : c_instr[16]);
        d_store  = d_mem & ~d_load;
        d_branch = (opc >= 5'd12) && (opc <= 5'd14);
        inc_mode = (opc == 5'd3) || (opc == 5'd6) || (opc == 5'd9);
        d_post   = inc_mode && (c_instr[15:14] == 2'd2);
        d_halt   = (opc == 5'd15) && (c_instr[6:0] == 7'd0);

        d_s1 = RIDX'(rb);
        if (opc == 5'd2 || ld_alt || opc == 5'd12 || opc == 5'd15 ||
            ((opc == 5'd0 || opc == 5'd1) && alu_op == 5'd6))
            d_s1 = '0;
        d_s2   = d_store ? RIDX'(ra) : ((opc == 5'd0) ? RIDX'(c_instr[4:0]) : '0);
        d_tgt1 = d_store ? '0 : RIDX'(ra);
        d_tgt2 = (inc_mode && c_instr[15:14] != 2'd0) ? RIDX'(rb) : '0;

        sx12  = {{(XLEN-12){c_instr[11]}}, c_instr[11:0]};
        d_imm = '0;
        case (opc)
            5'd1: begin
                if (alu_op <= 5'd6)
                    d_imm = XLEN'(c_instr[7:0]) << {c_instr[9:8], 3'b000};
                else if (alu_op <= 5'd13)
                    d_imm = XLEN'(c_instr[4:0]);
                else if (alu_op <= 5'd18)
                    d_imm = sx12;
            end
            5'd2:                d_imm = XLEN'(c_instr[21:0]) << 10;
            5'd12:               d_imm = {{(XLEN-22){c_instr[21]}}, c_instr[21:0]};
            5'd3, 5'd6, 5'd9:    d_imm = sx12 << c_instr[13:12];
            5'd4, 5'd7, 5'd10:   d_imm = {{(XLEN-16){c_instr[15]}}, c_instr[15:0]};
            5'd5, 5'd8, 5'd11:   d_imm = {{(XLEN-21){c_instr[20]}}, c_instr[20:0]};
            default:             d_imm = '0;
        endcase
    end

    // One bubble per dependent load: the bubble clears valid_out, which drops the interlock.
    assign hazard_stall = (LOAD_USE != 0) && valid_out && is_load_out && (tgt1_out != '0) &&
                          ((tgt1_out == d_s1) || (tgt1_out == d_s2)) && c_valid && !stall;

    always_ff @(posedge clk) begin
        if (!halt && !flush && push_ok) begin
            ibuf_mem[tail_reg] <= instr_in;
            pbuf_mem[tail_reg] <= pc_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else if (!halt) begin
            if (flush) begin
                head_reg  <= '0;
                tail_reg  <= '0;
                count_reg <= '0;
            end else begin
                if (push_ok) tail_reg <= ptr_inc(tail_reg);
                if (pop)     head_reg <= ptr_inc(head_reg);
                if (push_req && !push_ok) ovf_reg <= 1'b1;
                case ({push_ok, pop})
                    2'b10:   count_reg <= count_reg + CW'(1);
                    2'b01:   count_reg <= count_reg - CW'(1);
                    default: count_reg <= count_reg;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out       <= 1'b0;
            pc_out          <= '0;
            opcode_out      <= '0;
            s1_out          <= '0;
            s2_out          <= '0;
            tgt1_out        <= '0;
            tgt2_out        <= '0;
            alu_op_out      <= '0;
            imm_out         <= '0;
            branch_code_out <= '0;
            is_load_out     <= 1'b0;
            is_store_out    <= 1'b0;
            is_branch_out   <= 1'b0;
            is_post_inc_out <= 1'b0;
            halt_out        <= 1'b0;
        end else if (!halt && !stall) begin
            valid_out       <= out_valid;
            pc_out          <= c_pc;
            opcode_out      <= opc;
            s1_out          <= d_s1;
            s2_out          <= d_s2;
            tgt1_out        <= out_valid ? d_tgt1 : '0;
            tgt2_out        <= out_valid ? d_tgt2 : '0;
            alu_op_out      <= alu_op;
            imm_out         <= d_imm;
            branch_code_out <= c_instr[26:22];
            is_load_out     <= out_valid & d_load;
            is_store_out    <= out_valid & d_store;
            is_branch_out   <= out_valid & d_branch;
            is_post_inc_out <= out_valid & d_post;
            halt_out        <= out_valid & d_halt;
        end
    end
endmodule

// File: tb/tb_decode_replay_stage.sv
// Directed bench for decode_replay_stage: decoded words are checked against a queue of
// hand-derived expectations; FIFO, interlock, flush, halt and reset are checked inline.
module tb_decode_replay_stage;
    logic        clk, rst_n, halt, flush, stall, instr_valid;
    logic [31:0] instr_in, pc_in;
    logic        valid_out, is_load_out, is_store_out, is_branch_out, is_post_inc_out;
    logic        halt_out, hazard_stall, rbuf_ovf;
    logic [31:0] pc_out, imm_out;
    logic [4:0]  opcode_out, s1_out, s2_out, tgt1_out, tgt2_out, alu_op_out, branch_code_out;
    logic [1:0]  rbuf_count;

    decode_replay_stage dut (
        .clk(clk), .rst_n(rst_n), .halt(halt), .flush(flush), .stall(stall),
        .instr_in(instr_in), .instr_valid(instr_valid), .pc_in(pc_in),
        .valid_out(valid_out), .pc_out(pc_out), .opcode_out(opcode_out),
        .s1_out(s1_out), .s2_out(s2_out), .tgt1_out(tgt1_out), .tgt2_out(tgt2_out),
        .alu_op_out(alu_op_out), .imm_out(imm_out), .branch_code_out(branch_code_out),
        .is_load_out(is_load_out), .is_store_out(is_store_out), .is_branch_out(is_branch_out),
        .is_post_inc_out(is_post_inc_out), .halt_out(halt_out), .hazard_stall(hazard_stall),
        .rbuf_count(rbuf_count), .rbuf_ovf(rbuf_ovf)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  opc;
        logic [4:0]  s1, s2, t1, t2;
        logic [31:0] imm;
        logic        ld, st, br, pi, hl;
    } exp_t;

    localparam logic [4:0] FL_NONE = 5'b00000, FL_LD = 5'b10000, FL_ST = 5'b01000,
                           FL_BR = 5'b00100, FL_PI = 5'b00010, FL_HL = 5'b00001;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic load_q = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] opc, s1, s2, t1, t2,
                                input logic [31:0] imm, input logic [4:0] fl);
        exp_t e;
        e.pc = pc; e.opc = opc; e.s1 = s1; e.s2 = s2; e.t1 = t1; e.t2 = t2; e.imm = imm;
        {e.ld, e.st, e.br, e.pi, e.hl} = fl;
        return e;
    endfunction

    function automatic logic [31:0] enc_alu(input logic [4:0] ra, rb, rc, alu);
        return {5'd0, ra, rb, 7'd0, alu, rc};
    endfunction

    function automatic logic [31:0] enc_mem(input logic [4:0] ra, rb, input logic ld,
                                            input logic [15:0] imm);
        return {5'd4, ra, rb, ld, imm};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] w, input logic [31:0] pc);
        instr_in = w; pc_in = pc; instr_valid = 1'b1;
    endtask

    task automatic idle();
        instr_in = 32'd0; pc_in = 32'd0; instr_valid = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Output regs only reload on edges without stall/halt; those are the edges to score.
    initial forever begin
        @(posedge clk);
        load_q = rst_n && !stall && !halt;
    end

    initial forever begin
        exp_t e, o;
        @(negedge clk);
        if (load_q && valid_out) begin
            n_vec++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_output: observed pc %0h expected no output", pc_out);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                o = {pc_out, opcode_out, s1_out, s2_out, tgt1_out, tgt2_out, imm_out,
                     is_load_out, is_store_out, is_branch_out, is_post_inc_out, halt_out};
                n_vec++;
                assert (o === e) else begin
                    n_err++;
                    $error("FAIL decode_pc_%0h: observed %h expected %h", e.pc, o, e);
                end
            end
        end
    end

    initial begin
        logic [31:0] w;
        rst_n = 1'b0; halt = 1'b0; flush = 1'b0; stall = 1'b0;
        idle();
        tick(); tick();
        check("rst_valid", 64'(valid_out), 64'd0);
        check("rst_count", 64'(rbuf_count), 64'd0);
        check("rst_ovf", 64'(rbuf_ovf), 64'd0);
        check("rst_tgt1", 64'(tgt1_out), 64'd0);
        check("rst_imm_pc", {imm_out, pc_out}, 64'd0);
        rst_n = 1'b1;
        tick();

        // plain stream through the bypass path
        send(enc_alu(5'd4, 5'd5, 5'd6, 5'd1), 32'h100);
        sb.push_back(mk(32'h100, 5'd0, 5'd5, 5'd6, 5'd4, 5'd0, 32'h0, FL_NONE));
        tick();
        w = {5'd1, 5'd8, 5'd9, 5'd2, 2'b00, 2'b10, 8'hAB};
        send(w, 32'h104);
        sb.push_back(mk(32'h104, 5'd1, 5'd9, 5'd0, 5'd8, 5'd0, 32'h00AB0000, FL_NONE));
        tick();
        check("opc1_imm", 64'(imm_out), 64'h00AB0000);
        check("opc1_aluop", 64'(alu_op_out), 64'd2);
        send({5'd12, 5'd17, 22'h3FFFFC}, 32'h108);
        sb.push_back(mk(32'h108, 5'd12, 5'd0, 5'd0, 5'd17, 5'd0, 32'hFFFFFFFC, FL_BR));
        tick();
        send({5'd15, 27'd0}, 32'h10C);
        sb.push_back(mk(32'h10C, 5'd15, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, FL_HL));
        tick();
        idle(); tick(); tick();

        // stall two cycles while A,B arrive; they come out in order
        stall = 1'b1;
        send(enc_mem(5'd7, 5'd2, 1'b1, 16'h8000), 32'h200);
        sb.push_back(mk(32'h200, 5'd4, 5'd2, 5'd0, 5'd7, 5'd0, 32'hFFFF8000, FL_LD));
        tick();
        check("stall_count1", 64'(rbuf_count), 64'd1);
        send(enc_mem(5'd9, 5'd4, 1'b0, 16'h0010), 32'h204);
        sb.push_back(mk(32'h204, 5'd4, 5'd4, 5'd9, 5'd0, 5'd0, 32'h10, FL_ST));
        tick();
        check("stall_count2", 64'(rbuf_count), 64'd2);
        stall = 1'b0; idle();
        tick(); tick();
        check("drain_count", 64'(rbuf_count), 64'd0);
        tick();

        // overflow: three words into a two-entry FIFO
        check("ovf_clear", 64'(rbuf_ovf), 64'd0);
        stall = 1'b1;
        send(enc_alu(5'd10, 5'd11, 5'd12, 5'd1), 32'h280);
        sb.push_back(mk(32'h280, 5'd0, 5'd11, 5'd12, 5'd10, 5'd0, 32'h0, FL_NONE));
        tick();
        send({5'd3, 5'd13, 5'd14, 1'b1, 2'b10, 2'b01, 12'hFFF}, 32'h284);
        sb.push_back(mk(32'h284, 5'd3, 5'd14, 5'd0, 5'd13, 5'd14, 32'hFFFFFFFE, FL_LD | FL_PI));
        tick();
        send(enc_alu(5'd20, 5'd21, 5'd22, 5'd1), 32'h288);
        tick();
        check("ovf_set", 64'(rbuf_ovf), 64'd1);
        check("ovf_count", 64'(rbuf_count), 64'd2);
        stall = 1'b0; idle();
        tick(); tick(); tick();
        check("ovf_drained", 64'(rbuf_count), 64'd0);

        // load r3 followed by a consumer of r3
        send(enc_mem(5'd3, 5'd1, 1'b1, 16'h0004), 32'h300);
        sb.push_back(mk(32'h300, 5'd4, 5'd1, 5'd0, 5'd3, 5'd0, 32'h4, FL_LD));
        tick();
        send(enc_alu(5'd5, 5'd3, 5'd6, 5'd1), 32'h304);
        sb.push_back(mk(32'h304, 5'd0, 5'd3, 5'd6, 5'd5, 5'd0, 32'h0, FL_NONE));
        #1;
        check("hazard_on", 64'(hazard_stall), 64'd1);
        tick();
        check("bubble_valid", 64'(valid_out), 64'd0);
        check("bubble_count", 64'(rbuf_count), 64'd1);
        idle();
        #1;
        check("hazard_off", 64'(hazard_stall), 64'd0);
        tick();
        check("reissue_pc", 64'(pc_out), 64'h304);
        check("reissue_count", 64'(rbuf_count), 64'd0);

        // flush with two words queued
        stall = 1'b1;
        send(enc_alu(5'd1, 5'd2, 5'd3, 5'd1), 32'h400);
        tick();
        send(enc_alu(5'd1, 5'd2, 5'd3, 5'd1), 32'h404);
        tick();
        check("flush_pre_count", 64'(rbuf_count), 64'd2);
        stall = 1'b0; flush = 1'b1;
        send(enc_alu(5'd1, 5'd2, 5'd3, 5'd1), 32'h408);
        tick();
        check("flush_count", 64'(rbuf_count), 64'd0);
        check("flush_valid", 64'(valid_out), 64'd0);
        check("flush_tgt1", 64'(tgt1_out), 64'd0);
        flush = 1'b0; idle();
        tick();
        check("post_flush_valid", 64'(valid_out), 64'd0);

        // halt freezes the stage
        send({5'd15, 27'd0}, 32'h500);
        sb.push_back(mk(32'h500, 5'd15, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, FL_HL));
        tick();
        halt = 1'b1;
        send(enc_alu(5'd1, 5'd2, 5'd3, 5'd6), 32'h504);
        tick();
        check("halt_pc", 64'(pc_out), 64'h500);
        check("halt_haltout", 64'(halt_out), 64'd1);
        tick();
        check("halt_count", 64'(rbuf_count), 64'd0);
        check("halt_valid", 64'(valid_out), 64'd1);
        halt = 1'b0;
        sb.push_back(mk(32'h504, 5'd0, 5'd0, 5'd3, 5'd1, 5'd0, 32'h0, FL_NONE));
        tick();
        idle(); tick();

        // reset asserted mid-stream
        send(enc_alu(5'd2, 5'd3, 5'd4, 5'd1), 32'h600);
        sb.push_back(mk(32'h600, 5'd0, 5'd3, 5'd4, 5'd2, 5'd0, 32'h0, FL_NONE));
        tick();
        stall = 1'b1;
        send(enc_alu(5'd6, 5'd7, 5'd8, 5'd1), 32'h604);
        tick();
        check("pre_rst_count", 64'(rbuf_count), 64'd1);
        check("ovf_sticky", 64'(rbuf_ovf), 64'd1);
        check("pre_rst_valid", 64'(valid_out), 64'd1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", 64'(valid_out), 64'd0);
        check("mid_rst_count", 64'(rbuf_count), 64'd0);
        check("mid_rst_tgt1", 64'(tgt1_out), 64'd0);
        check("mid_rst_ovf", 64'(rbuf_ovf), 64'd0);
        rst_n = 1'b1; stall = 1'b0; idle();
        tick(); tick(); tick();
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
